// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer: holds N_STAGE resets until PLL lock is filtered stable, then frees them in order.
// Outputs are registered (one edge from the decision); lock loss or sw reset re-asserts every stage on the next edge.
module rst_seq_ctrl #(
  parameter int N_STAGE   = 4,
  parameter int STAGE_DLY = 1000,
  parameter int LOCK_FILT = 64,
  parameter int SWRST_LEN = 16
) (
  input  logic               i_in_clk,
  input  logic               i_rst_async,
  input  logic               i_pll_locked,
  input  logic               i_sw_rst,
  output logic [N_STAGE-1:0] o_rst_stage,
  output logic               o_seq_done,
  output logic [1:0]         o_state,
  output logic [7:0]         o_relock_cnt
);

  localparam int DW = $clog2(STAGE_DLY + 1);
  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int CW = $clog2(SWRST_LEN + 1);
  localparam int KW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_DLY - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SWRST_LEN - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(N_STAGE - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_SWRST     = 2'd3
  } state_t;

  logic               lock_meta_q;
  logic               lock_s_q;
  state_t             state_q;
  logic [N_STAGE-1:0] rst_stage_q;
  logic               seq_done_q;
  logic [7:0]         relock_cnt_q;
  logic [FW-1:0]      filt_q;
  logic [DW-1:0]      dly_q;
  logic [KW-1:0]      idx_q;
  logic [CW-1:0]      hold_q;

  // PLL lock is asynchronous to this domain; only lock_s_q is ever used below.
  always_ff @(posedge i_in_clk or posedge i_rst_async) begin
    if (i_rst_async) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= i_pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge i_in_clk or posedge i_rst_async) begin
    if (i_rst_async) begin
      state_q      <= ST_WAIT_LOCK;
      rst_stage_q  <= '1;
      seq_done_q   <= 1'b0;
      relock_cnt_q <= 8'd0;
      filt_q       <= '0;
      dly_q        <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
    end else if (i_sw_rst) begin
      // Software request wins over lock loss, so the relock count is left alone here.
      state_q     <= ST_SWRST;
      rst_stage_q <= '1;
      seq_done_q  <= 1'b0;
      hold_q      <= '0;
      filt_q      <= '0;
      dly_q       <= '0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (!lock_s_q) begin
            filt_q <= '0;
          end else if (filt_q == FILT_LAST) begin
            state_q <= ST_RELEASE;
            filt_q  <= '0;
            dly_q   <= '0;
            idx_q   <= '0;
          end else begin
            filt_q <= filt_q + 1'b1;
          end
        end

        ST_RELEASE, ST_RUN: begin
          if (!lock_s_q) begin
            state_q     <= ST_WAIT_LOCK;
            rst_stage_q <= '1;
            seq_done_q  <= 1'b0;
            filt_q      <= '0;
            dly_q       <= '0;
            idx_q       <= '0;
            if (relock_cnt_q != 8'hFF) begin
              relock_cnt_q <= relock_cnt_q + 1'b1;
            end
          end else if (state_q == ST_RELEASE) begin
            if (dly_q == DLY_LAST) begin
              dly_q              <= '0;
              rst_stage_q[idx_q] <= 1'b0;
              idx_q              <= idx_q + 1'b1;
              if (idx_q == K_LAST) begin
                state_q    <= ST_RUN;
                seq_done_q <= 1'b1;
              end
            end else begin
              dly_q <= dly_q + 1'b1;
            end
          end
        end

        ST_SWRST: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_WAIT_LOCK;
            filt_q  <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_rst_stage  = rst_stage_q;
  assign o_seq_done   = seq_done_q;
  assign o_state      = state_q;
  assign o_relock_cnt = relock_cnt_q;

endmodule
